// File: rtl/seg7_scanner.sv
// ============================================================================
// Module   : seg7_scanner
// Purpose  : 4-digit multiplexed hex 7-segment scanner with frame snapshot,
//            leading-zero blanking and synchronized scan-clock tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scanner #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_div,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx
);

  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};

  logic        s1_q, s2_q, s3_q;
  logic        en_q;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] snap_val_q, snap_val_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;

  logic        scan_tick;
  logic        en_rise;
  logic [3:0]  nib;
  logic [3:0]  zero_from;
  logic        blank;
  logic [6:0]  seg_on;
  logic        dp_on;
  logic [3:0]  an_on;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign scan_tick = s2_q & ~s3_q;
  assign en_rise   = enable & ~en_q;

  // Outputs are decoded from next-state index/snapshot so an and seg switch together.
  always_comb begin
    idx_d      = idx_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    if (enable) begin
      if (en_rise) begin
        idx_d      = 2'd0;
        snap_val_d = value;
        snap_dp_d  = dp;
      end else if (scan_tick) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          snap_val_d = value;
          snap_dp_d  = dp;
        end
      end
    end
  end

  always_comb begin
    nib          = snap_val_d[{idx_d, 2'b00} +: 4];
    zero_from[3] = (snap_val_d[15:12] == 4'h0);
    zero_from[2] = zero_from[3] & (snap_val_d[11:8] == 4'h0);
    zero_from[1] = zero_from[2] & (snap_val_d[7:4] == 4'h0);
    zero_from[0] = zero_from[1] & (snap_val_d[3:0] == 4'h0);
    blank        = BLANK_LEADING && (idx_d != 2'd0) && zero_from[idx_d];
    seg_on       = blank ? 7'h00 : hex_decode(nib);
    dp_on        = snap_dp_d[idx_d];
    an_on        = 4'b0001 << idx_d;
    if (!enable) begin
      seg_on = 7'h00;
      dp_on  = 1'b0;
      an_on  = 4'h0;
    end
    seg_d = seg_on ^ SEG_OFF;
    dp_d  = dp_on ^ DP_OFF;
    an_d  = an_on ^ AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      en_q       <= 1'b0;
      idx_q      <= 2'd0;
      snap_val_q <= 16'h0000;
      snap_dp_q  <= 4'h0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
    end else begin
      s1_q       <= clk_div;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      en_q       <= enable;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp_out    = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

`default_nettype wire

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = seg/dp_out drive 0 to light a segment.
REQ-002 SHALL have parameter AN_ACTIVE_LOW, default 1: 1 = an drives 0 to select a digit.
REQ-003 SHALL have parameter BLANK_LEADING, default 1: 1 = blank leading zero digits.
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz, rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clk_div  input  1  slow square-wave scan clock from the clock divider; treated as asynchronous data, never as a clock.
REQ-007 SHALL have port enable  input  1  1 = scanning active; 0 = display dark.
REQ-008 SHALL have port value  input  16  four nibbles; digit0 = value[3:0] (rightmost), digit3 = value[15:12].
REQ-009 SHALL have port dp  input  4  decimal point request per digit, bit i = digit i.
REQ-010 SHALL have port seg  output  7  segments, seg[0]=a ... seg[6]=g, registered.
REQ-011 SHALL have port dp_out  output  1  decimal point of the selected digit, registered.
REQ-012 SHALL have port an  output  4  one-hot digit select, bit i = digit i, registered.
REQ-013 SHALL have port digit_idx  output  2  index of the currently selected digit, registered.

Function
REQ-014 SHALL pass clk_div through a 2-flop synchronizer (s1, s2) plus a history flop s3; scan_tick = s2 & ~s3.
REQ-015 A clk_div rise meeting setup before clk edge k SHALL update digit_idx/an/seg/dp_out at edge k+2 (3rd edge counting k); exactly one tick per clk_div rise; falls produce none.
REQ-016 On scan_tick with enable=1, digit_idx SHALL advance 0->1->2->3->0 (2-bit wrap).
REQ-017 A frame snapshot of value and dp SHALL load on the same edge digit_idx wraps 3->0 and when enable rises 0->1; all four digits of one frame SHALL display from the same snapshot (no tearing).
REQ-018 seg SHALL be the hex decode of the selected snapshot nibble, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; inverted when SEG_ACTIVE_LOW=1.
REQ-019 With BLANK_LEADING=1, digit i (i>=1) SHALL be blank (all segments off) when snapshot nibbles i..3 are all zero; digit0 SHALL never be blanked; dp_out SHALL follow dp snapshot regardless of blanking.
REQ-020 an SHALL be one-hot on bit digit_idx while enable=1; SHALL change on the same edge as seg so digit/segment data never mismatch.
REQ-021 enable=0 SHALL force an all-inactive, seg and dp_out all-off on the next edge; digit_idx SHALL hold; ticks SHALL be ignored.
REQ-022 enable 0->1 SHALL restart at digit_idx=0 with a fresh snapshot, output on the next edge without waiting for a tick.
REQ-023 value/dp changes mid-frame SHALL NOT affect outputs until the next snapshot.
REQ-024 clk_div held constant SHALL freeze the scan at the current digit with outputs stable.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) clear s1/s2/s3, digit_idx=0, snapshot=0, an all-inactive (4'hF when AN_ACTIVE_LOW=1), seg and dp_out all-off (7'h7F/1 when SEG_ACTIVE_LOW=1).
REQ-026 After rst deasserts, a clk_div already high SHALL NOT generate a tick until it falls and rises again... unless s3 was 0: a high clk_div at release SHALL produce exactly one tick (s3 reset to 0).
REQ-027 rst mid-frame SHALL discard the frame; first post-reset frame starts at digit0 with a snapshot taken when enable is first seen high.

Verification
REQ-028 Defaults, enable=1, value=16'h1234, dp=4'b0100, clk_div toggled every 8 clk -> an cycles E,D,B,7; seg = ~06,~5B,~4F,~66 for digits 3..0 in order 4,3,2,1; dp_out=0 only while an=4'hB.
REQ-029 value=16'h0070, BLANK_LEADING=1 -> digit3 and digit2 seg=7F, digit1 seg=~07=78, digit0 seg=~3F=40.
REQ-030 Change value from 16'h1111 to 16'h2222 while digit_idx=1 -> digits 1..3 still show 1 (seg=79); 2 (seg=24) first appears at the next digit_idx=0.
REQ-031 clk_div rises before edge k -> outputs change exactly at edge k+2; clk_div 1-clk glitch meeting setup -> exactly one advance; fall -> none.
REQ-032 enable dropped at digit_idx=2 -> next edge an=F, seg=7F; re-raise -> next edge an=E, digit_idx=0.
REQ-033 rst pulse between clk edges mid-scan -> outputs reach reset values before the next clk edge; scanning resumes from digit0.
